// File: rtl/decoder_pkg.sv
// Shared types and helpers for the binary-to-one-hot decoder family.
// The one-hot helper is sized for the widest supported code; callers truncate to their own width.
package decoder_pkg;

  localparam int MAX_IN_W  = 8;
  localparam int MAX_OUT_W = 1 << MAX_IN_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWEEP_EMIT = 2'd1,
    SWEEP_GAP  = 2'd2
  } state_t;

  // The shift is done at full output width so the top code never falls off the end.
  function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [MAX_IN_W-1:0] code);
    return MAX_OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_nto2n_seq_if.sv
// Handshake bundle for decoder_nto2n_seq: upstream code port, sweep control and the registered beat.
// The master modport is the environment (producer of codes, consumer of beats); slave is the decoder.
interface decoder_nto2n_seq_if #(
  parameter int IN_W = 3
);

  localparam int OUT_W = 1 << IN_W;

  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_code;
  logic              sweep_start;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_onehot;
  logic [IN_W-1:0]   out_code;
  logic              sweep_done;

  modport master (
    output mode, in_valid, in_code, sweep_start, out_ready,
    input  in_ready, out_valid, out_onehot, out_code, sweep_done
  );

  modport slave (
    input  mode, in_valid, in_code, sweep_start, out_ready,
    output in_ready, out_valid, out_onehot, out_code, sweep_done
  );

endinterface

// File: rtl/onehot_dec.sv
// Combinational IN_W -> 2**IN_W binary-to-one-hot decoder.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]        code,
  output logic [(1 << IN_W)-1:0] onehot
);

  localparam int OUT_W = 1 << IN_W;

  assign onehot = OUT_W'(onehot_of(MAX_IN_W'(code)));

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with a single-slot valid/ready output and a self-timed
// sweep mode that walks every output line with DWELL-1 idle cycles after each accepted beat.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int DWELL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_nto2n_seq_if.slave  bus
);

  localparam int OUT_W = 1 << IN_W;
  localparam int GAP_W = $clog2(DWELL + 1);

  localparam logic [IN_W-1:0]  LAST_CODE = IN_W'(OUT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((DWELL > 1) ? (DWELL - 2) : 0);

  state_t            state;
  logic [IN_W-1:0]   sweep_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_q;

  logic              slot_free;
  logic              beat_accept;
  logic [IN_W-1:0]   dec_code;
  logic [OUT_W-1:0]  dec_onehot;

  assign slot_free   = !bus.out_valid || bus.out_ready;
  assign beat_accept = bus.out_valid && bus.out_ready;

  // Upstream is only served in IDLE with direct mode selected; during a sweep in_valid is dropped.
  assign bus.in_ready = (state == IDLE) && (bus.mode == MODE_DIRECT) && slot_free;

  assign dec_code = (state == IDLE) ? bus.in_code : sweep_cnt;

  onehot_dec #(
    .IN_W (IN_W)
  ) u_dec (
    .code   (dec_code),
    .onehot (dec_onehot)
  );

  // NOTE: every register here uses non-blocking assignment so all state updates see the
  // pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sweep_cnt      <= '0;
      gap_cnt        <= '0;
      last_q         <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_onehot <= '0;
      bus.out_code   <= '0;
      bus.sweep_done <= 1'b0;
    end else begin
      bus.sweep_done <= 1'b0;

      // A beat leaving the slot empties it; a load later in this block refills it.
      if (beat_accept) begin
        bus.out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.out_valid  <= 1'b1;
            bus.out_onehot <= dec_onehot;
            bus.out_code   <= dec_code;
          end else if (bus.sweep_start && (bus.mode == MODE_SWEEP)) begin
            sweep_cnt <= '0;
            last_q    <= 1'b0;
            state     <= SWEEP_EMIT;
          end
        end

        SWEEP_EMIT: begin
          if (last_q) begin
            // Termination keys off the last flag, so the all-ones code needs no wrap detection.
            if (beat_accept) begin
              last_q         <= 1'b0;
              bus.sweep_done <= 1'b1;
              state          <= IDLE;
            end
          end else if (slot_free) begin
            bus.out_valid  <= 1'b1;
            bus.out_onehot <= dec_onehot;
            bus.out_code   <= dec_code;
            if (sweep_cnt == LAST_CODE) begin
              last_q <= 1'b1;
            end else if (DWELL > 1) begin
              gap_cnt <= '0;
              state   <= SWEEP_GAP;
            end else begin
              sweep_cnt <= sweep_cnt + IN_W'(1);
            end
          end
        end

        SWEEP_GAP: begin
          // The gap clock starts on the acceptance cycle; a stalled beat holds it at zero.
          if (slot_free) begin
            if (gap_cnt == GAP_LAST) begin
              sweep_cnt <= sweep_cnt + IN_W'(1);
              state     <= SWEEP_EMIT;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_onehot_matches_code : assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.out_valid |-> (bus.out_onehot == OUT_W'(onehot_of(MAX_IN_W'(bus.out_code))))
  );

  a_beat_held_under_stall : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_code) && $stable(bus.out_onehot))
  );

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq: a 3-bit/DWELL=1 instance and a 4-bit/DWELL=3 instance
// share clock and reset; stimulus pushes expected beats, per-instance monitors pop and compare.
module tb_decoder_nto2n_seq;

  localparam int A_IN_W  = 3;
  localparam int A_DWELL = 1;
  localparam int B_IN_W  = 4;
  localparam int B_DWELL = 3;

  typedef struct {
    int code;
    int due;
    bit sweep;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q_a[$];
  exp_t q_b[$];
  int   done_exp_a;
  int   done_exp_b;
  int   done_seen_b;
  int   beats_a;
  int   last_acc_a;
  int   last_acc_b;
  bit   stall_a;
  bit   stall_b;
  int   held_a;
  int   held_b;

  decoder_nto2n_seq_if #(.IN_W(A_IN_W)) bus_a ();
  decoder_nto2n_seq_if #(.IN_W(B_IN_W)) bus_b ();

  decoder_nto2n_seq #(.IN_W(A_IN_W), .DWELL(A_DWELL)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  decoder_nto2n_seq #(.IN_W(B_IN_W), .DWELL(B_DWELL)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 3-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_stall_valid", int'(bus_a.out_valid), 1);
        check("a_stall_code", int'(bus_a.out_code), held_a);
      end
      if (bus_a.sweep_done) begin
        check("a_done_expected", done_exp_a, 1);
        if (done_exp_a > 0) begin
          done_exp_a--;
          check("a_done_cycle", cyc, last_acc_a + 1);
        end
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        beats_a++;
        check("a_beat_expected", int'(q_a.size() != 0), 1);
        if (q_a.size() != 0) begin
          exp_t e;
          e = q_a.pop_front();
          check("a_code", int'(bus_a.out_code), e.code);
          check("a_onehot", int'(bus_a.out_onehot), 1 << e.code);
          if (e.due >= 0) check("a_beat_cycle", cyc, e.due);
          if (e.sweep) last_acc_a = cyc;
        end
      end
      stall_a = bus_a.out_valid && !bus_a.out_ready;
      held_a  = int'(bus_a.out_code);
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        check("b_stall_valid", int'(bus_b.out_valid), 1);
        check("b_stall_code", int'(bus_b.out_code), held_b);
      end
      if (bus_b.sweep_done) begin
        done_seen_b++;
        check("b_done_expected", done_exp_b, 1);
        if (done_exp_b > 0) begin
          done_exp_b--;
          check("b_done_cycle", cyc, last_acc_b + 1);
        end
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        check("b_beat_expected", int'(q_b.size() != 0), 1);
        if (q_b.size() != 0) begin
          exp_t e;
          e = q_b.pop_front();
          check("b_code", int'(bus_b.out_code), e.code);
          check("b_onehot", int'(bus_b.out_onehot), 1 << e.code);
          if (e.sweep && e.code != 0) check("b_sweep_gap", int'((cyc - last_acc_b) >= B_DWELL), 1);
          if (e.sweep) last_acc_b = cyc;
        end
      end
      stall_b = bus_b.out_valid && !bus_b.out_ready;
      held_b  = int'(bus_b.out_code);
    end
  end

  initial begin
    int start_beats;
    bit found;

    checks = 0; errors = 0;
    done_exp_a = 0; done_exp_b = 0; done_seen_b = 0; beats_a = 0;
    last_acc_a = 0; last_acc_b = 0;
    rst_n = 1'b0;
    bus_a.mode = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_code = '0;
    bus_a.sweep_start = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.mode = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_code = '0;
    bus_b.sweep_start = 1'b0; bus_b.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", int'(bus_a.out_valid), 0);
    check("rst_a_onehot", int'(bus_a.out_onehot), 0);
    check("rst_a_code", int'(bus_a.out_code), 0);
    check("rst_a_done", int'(bus_a.sweep_done), 0);
    check("rst_b_valid", int'(bus_b.out_valid), 0);
    check("rst_b_onehot", int'(bus_b.out_onehot), 0);
    check("rst_b_done", int'(bus_b.sweep_done), 0);
    next_cycle();
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;

    // Direct decode, codes 0..7 back-to-back, latency 1, no bubbles.
    for (int i = 0; i < 8; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_code  = 3'(i);
      q_a.push_back(exp_t'{i, cyc + 1, 1'b0});
      @(negedge clk);
      check("a_in_ready_direct", int'(bus_a.in_ready), 1);
      next_cycle();
    end
    bus_a.in_valid = 1'b0;
    repeat (2) next_cycle();

    // Backpressure: code 5 held four cycles, code 6 accepted as out_ready rises.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_code   = 3'd5;
    q_a.push_back(exp_t'{5, cyc + 5, 1'b0});
    @(negedge clk);
    check("a_in_ready_empty", int'(bus_a.in_ready), 1);
    next_cycle();
    bus_a.in_code = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a_in_ready_stalled", int'(bus_a.in_ready), 0);
      check("a_held_onehot", int'(bus_a.out_onehot), 32);
      next_cycle();
    end
    bus_a.out_ready = 1'b1;
    bus_a.in_code   = 3'd6;
    q_a.push_back(exp_t'{6, cyc + 1, 1'b0});
    @(negedge clk);
    check("a_in_ready_release", int'(bus_a.in_ready), 1);
    next_cycle();
    bus_a.in_valid = 1'b0;
    repeat (2) next_cycle();

    // Sweep on the 3-bit instance; in_valid dropped, mode flipped mid-sweep.
    bus_a.mode        = 1'b1;
    bus_a.sweep_start = 1'b1;
    for (int k = 0; k < 8; k++) q_a.push_back(exp_t'{k, cyc + 2 + k, 1'b1});
    done_exp_a = 1;
    next_cycle();
    bus_a.sweep_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_code  = 3'($urandom_range(0, 7));
      if (k == 3) bus_a.mode = 1'b0;
      @(negedge clk);
      check("a_in_ready_sweep", int'(bus_a.in_ready), 0);
      next_cycle();
    end
    bus_a.in_valid = 1'b0;
    repeat (4) next_cycle();
    check("a_sweep_drained", q_a.size(), 0);
    check("a_sweep_done_seen", done_exp_a, 0);

    // sweep_start with mode=0 produces nothing.
    start_beats = beats_a;
    bus_a.sweep_start = 1'b1;
    next_cycle();
    bus_a.sweep_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("a_no_beat_mode0", int'(bus_a.out_valid), 0);
      next_cycle();
    end
    check("a_no_beats_mode0", beats_a - start_beats, 0);

    // 4-bit sweep with DWELL=3 under random out_ready, alongside random direct traffic on A.
    bus_b.mode        = 1'b1;
    bus_b.sweep_start = 1'b1;
    for (int k = 0; k < 16; k++) q_b.push_back(exp_t'{k, -1, 1'b1});
    done_exp_b = 1;
    next_cycle();
    bus_b.sweep_start = 1'b0;
    for (int n = 0; n < 600 && done_seen_b == 0; n++) begin
      bus_b.out_ready = ($urandom_range(0, 3) != 0);
      bus_b.in_valid  = (n < 20);
      bus_b.in_code   = 4'($urandom_range(0, 15));
      if (n == 5) bus_b.mode = 1'b0;
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.in_code   = 3'($urandom_range(0, 7));
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus_a.in_valid && bus_a.in_ready) q_a.push_back(exp_t'{int'(bus_a.in_code), -1, 1'b0});
      if (n < 20) check("b_in_ready_sweep", int'(bus_b.in_ready), 0);
      next_cycle();
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
    repeat (4) next_cycle();
    check("b_sweep_done_count", done_seen_b, 1);
    check("b_sweep_drained", q_b.size(), 0);
    check("a_random_drained", q_a.size(), 0);

    // Reset while code 4 of a sweep is stalled: no done, then direct decode works.
    bus_a.mode        = 1'b1;
    bus_a.sweep_start = 1'b1;
    for (int k = 0; k < 8; k++) q_a.push_back(exp_t'{k, -1, 1'b1});
    done_exp_a = 1;
    next_cycle();
    bus_a.sweep_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (bus_a.out_valid && bus_a.out_code == 3'd3) found = 1'b1;
      next_cycle();
    end
    check("a_reached_code3", int'(found), 1);
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("a_stalled_code4", int'(bus_a.out_code), 4);
      next_cycle();
    end
    rst_n = 1'b0;
    q_a.delete();
    done_exp_a = 0;
    @(negedge clk);
    check("a_midreset_valid", int'(bus_a.out_valid), 0);
    check("a_midreset_onehot", int'(bus_a.out_onehot), 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    bus_a.mode      = 1'b0;
    bus_a.out_ready = 1'b1;
    next_cycle();
    bus_a.in_valid = 1'b1;
    bus_a.in_code  = 3'd2;
    q_a.push_back(exp_t'{2, cyc + 1, 1'b0});
    @(negedge clk);
    check("a_in_ready_after_reset", int'(bus_a.in_ready), 1);
    next_cycle();
    bus_a.in_valid = 1'b0;
    repeat (6) next_cycle();
    check("a_final_drained", q_a.size(), 0);
    check("a_no_done_pending", done_exp_a, 0);
    check("b_final_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
